// File: rtl/riscv_pkg.sv
// Shared constants for the RV32 execute stage.
//   ALU_*  : alu_op encodings for the arithmetic/logic path
//   BR_*   : alu_op encodings when ctrl[CTRL_BRANCH] is set
//   MUL_*  : alu_op encodings when ctrl[CTRL_MUL] is set
//   CTRL_* : bit positions inside the 8-bit control word
//   MUL_IDLE/BUSY/DONE : iterative multiplier FSM states
package riscv_pkg;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  localparam logic [3:0] BR_EQ  = 4'd0;
  localparam logic [3:0] BR_NE  = 4'd1;
  localparam logic [3:0] BR_LT  = 4'd4;
  localparam logic [3:0] BR_GE  = 4'd5;
  localparam logic [3:0] BR_LTU = 4'd6;
  localparam logic [3:0] BR_GEU = 4'd7;

  localparam logic [3:0] MUL_LO = 4'd0;
  localparam logic [3:0] MUL_HU = 4'd3;

  localparam int unsigned CTRL_REG_WRITE   = 0;
  localparam int unsigned CTRL_ALU_SRC_IMM = 1;
  localparam int unsigned CTRL_MEM_READ    = 2;
  localparam int unsigned CTRL_MEM_WRITE   = 3;
  localparam int unsigned CTRL_BRANCH      = 4;
  localparam int unsigned CTRL_JUMP        = 5;
  localparam int unsigned CTRL_PC_REL      = 6;
  localparam int unsigned CTRL_MUL         = 7;

  typedef logic [1:0] mul_state_t;
  localparam mul_state_t MUL_IDLE = 2'd0;
  localparam mul_state_t MUL_BUSY = 2'd1;
  localparam mul_state_t MUL_DONE = 2'd2;

endpackage

// File: rtl/mul_iter.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request; accepted only in IDLE (operands latched then)
//   flush      : abort; returns to IDLE on the next edge from any state
//   a, b       : unsigned operands
//   hi_sel     : 1 selects the upper half of the product (MULHU)
//   busy       : iterating
//   done       : product valid this cycle (single cycle)
//   result     : selected half of the product
module mul_iter
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned MUL_ITERS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            hi_sel,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(MUL_ITERS - 1);

  mul_state_t            state_q, state_d;
  logic [CntW-1:0]       count_q, count_d;
  // Upper half accumulates partial sums; lower half starts as the multiplier
  // and is shifted out one bit per step as product bits shift in.
  logic [2*XLEN-1:0]     acc_q, acc_d;
  logic [XLEN-1:0]       a_q, a_d;
  logic                  hi_q, hi_d;
  logic [XLEN:0]         sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MUL_IDLE;
      count_q <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      hi_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    a_d     = a_q;
    hi_d    = hi_q;
    sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    if (flush) begin
      state_d = MUL_IDLE;
    end else begin
      case (state_q)
        MUL_IDLE: begin
          if (start) begin
            a_d     = a;
            acc_d   = {{XLEN{1'b0}}, b};
            count_d = '0;
            hi_d    = hi_sel;
            state_d = MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          acc_d   = {sum, acc_q[XLEN-1:1]};
          count_d = count_q + 1'b1;
          if (count_q == LastCnt) state_d = MUL_DONE;
        end
        MUL_DONE: state_d = MUL_IDLE;
        default:  state_d = MUL_IDLE;
      endcase
    end
  end

  assign busy   = (state_q == MUL_BUSY);
  assign done   = (state_q == MUL_DONE);
  assign result = hi_q ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];

endmodule

// File: rtl/execute_stage.sv
// RV32 execute stage: operand forwarding, ALU, branch/jump resolution and an
// iterative multiplier that stalls upstream until its product is ready.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   pc, imm, rs1, rs2, rd      : decoded instruction fields
//   rs1_data, rs2_data         : register-file operands
//   alu_op, ctrl               : operation select and control word (0 = bubble)
//   fwd_mem_*, fwd_wb_*        : EX/MEM and MEM/WB bypass sources
//   flush                      : kill the current instruction
//   ex_result, ex_store_data   : result and forwarded rs2 to EX/MEM
//   ex_rd, ex_ctrl             : destination and control to EX/MEM
//   branch_taken, branch_target: fetch redirect
//   stall                      : hold upstream pipeline registers
module execute_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned MUL_ITERS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [3:0]      alu_op,
  input  logic [7:0]      ctrl,
  input  logic            fwd_mem_we,
  input  logic [4:0]      fwd_mem_rd,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic            fwd_wb_we,
  input  logic [4:0]      fwd_wb_rd,
  input  logic [XLEN-1:0] fwd_wb_data,
  input  logic            flush,
  output logic [XLEN-1:0] ex_result,
  output logic [XLEN-1:0] ex_store_data,
  output logic [4:0]      ex_rd,
  output logic [7:0]      ex_ctrl,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_target,
  output logic            stall
);

  logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_res, mul_res;
  logic [4:0]      shamt;
  logic            br_cond, mul_busy, mul_done;

  // Youngest producer wins; x0 is hard-wired zero and never bypassed.
  always_comb begin
    fwd_a = rs1_data;
    if (fwd_mem_we && fwd_mem_rd != 5'd0 && fwd_mem_rd == rs1)   fwd_a = fwd_mem_data;
    else if (fwd_wb_we && fwd_wb_rd != 5'd0 && fwd_wb_rd == rs1) fwd_a = fwd_wb_data;
    fwd_b = rs2_data;
    if (fwd_mem_we && fwd_mem_rd != 5'd0 && fwd_mem_rd == rs2)   fwd_b = fwd_mem_data;
    else if (fwd_wb_we && fwd_wb_rd != 5'd0 && fwd_wb_rd == rs2) fwd_b = fwd_wb_data;
  end

  assign op_b  = ctrl[CTRL_ALU_SRC_IMM] ? imm : fwd_b;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:    alu_res = fwd_a + op_b;
      ALU_SUB:    alu_res = fwd_a - op_b;
      ALU_SLL:    alu_res = fwd_a << shamt;
      ALU_SLT:    alu_res = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(op_b)};
      ALU_SLTU:   alu_res = {{(XLEN-1){1'b0}}, fwd_a < op_b};
      ALU_XOR:    alu_res = fwd_a ^ op_b;
      ALU_SRL:    alu_res = fwd_a >> shamt;
      ALU_SRA:    alu_res = XLEN'($signed(fwd_a) >>> shamt);
      ALU_OR:     alu_res = fwd_a | op_b;
      ALU_AND:    alu_res = fwd_a & op_b;
      ALU_PASS_B: alu_res = op_b;
      default:    alu_res = '0;
    endcase
  end

  // Branch compares the two register operands, never the immediate.
  always_comb begin
    br_cond = 1'b0;
    case (alu_op)
      BR_EQ:   br_cond = (fwd_a == fwd_b);
      BR_NE:   br_cond = (fwd_a != fwd_b);
      BR_LT:   br_cond = ($signed(fwd_a) < $signed(fwd_b));
      BR_GE:   br_cond = ($signed(fwd_a) >= $signed(fwd_b));
      BR_LTU:  br_cond = (fwd_a < fwd_b);
      BR_GEU:  br_cond = (fwd_a >= fwd_b);
      default: br_cond = 1'b0;
    endcase
  end

  mul_iter #(
    .XLEN      (XLEN),
    .MUL_ITERS (MUL_ITERS)
  ) u_mul_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (ctrl[CTRL_MUL]),
    .flush  (flush),
    .a      (fwd_a),
    .b      (fwd_b),
    .hi_sel (alu_op == MUL_HU),
    .busy   (mul_busy),
    .done   (mul_done),
    .result (mul_res)
  );

  always_comb begin
    ex_result = alu_res;
    if (ctrl[CTRL_MUL] && mul_done) begin
      ex_result = mul_res;
    end else if (ctrl[CTRL_JUMP]) begin
      ex_result = pc + XLEN'(4);
    end else if (ctrl[CTRL_PC_REL] && !ctrl[CTRL_BRANCH]) begin
      ex_result = pc + imm;
    end
  end

  always_comb begin
    branch_target = pc + imm;
    if (ctrl[CTRL_JUMP] && !ctrl[CTRL_PC_REL]) begin
      branch_target = (fwd_a + imm) & ~XLEN'(1);
    end
  end

  // Outputs that steer the pipeline are forced quiet during reset and flush
  // so a half-decoded instruction cannot leak a redirect or a hold.
  assign stall = rst_n && !flush && (mul_busy || (ctrl[CTRL_MUL] && !mul_done));
  assign ex_ctrl = (!rst_n || flush || stall) ? 8'd0 : ctrl;
  assign branch_taken = rst_n && !flush && !stall &&
                        (ctrl[CTRL_JUMP] || (ctrl[CTRL_BRANCH] && br_cond));
  assign ex_store_data = fwd_b;
  assign ex_rd         = rd;

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc, imm, rs1_data, rs2_data, fwd_mem_data, fwd_wb_data;
  logic [4:0]  rs1, rs2, rd, fwd_mem_rd, fwd_wb_rd;
  logic [3:0]  alu_op;
  logic [7:0]  ctrl;
  logic        fwd_mem_we, fwd_wb_we, flush;
  logic [31:0] ex_result, ex_store_data, branch_target;
  logic [4:0]  ex_rd;
  logic [7:0]  ex_ctrl;
  logic        branch_taken, stall;

  int checks = 0;
  int errors = 0;
  int stall_cnt;

  execute_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc            (pc),
    .imm           (imm),
    .rs1           (rs1),
    .rs2           (rs2),
    .rd            (rd),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .alu_op        (alu_op),
    .ctrl          (ctrl),
    .fwd_mem_we    (fwd_mem_we),
    .fwd_mem_rd    (fwd_mem_rd),
    .fwd_mem_data  (fwd_mem_data),
    .fwd_wb_we     (fwd_wb_we),
    .fwd_wb_rd     (fwd_wb_rd),
    .fwd_wb_data   (fwd_wb_data),
    .flush         (flush),
    .ex_result     (ex_result),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .ex_ctrl       (ex_ctrl),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    pc = 32'h0; imm = 32'h0; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3;
    rs1_data = 32'h0; rs2_data = 32'h0; alu_op = 4'd0; ctrl = 8'h00;
    fwd_mem_we = 1'b0; fwd_mem_rd = 5'd0; fwd_mem_data = 32'h0;
    fwd_wb_we = 1'b0; fwd_wb_rd = 5'd0; fwd_wb_data = 32'h0; flush = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    ctrl  = 8'h81;
    settle();
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_ex_ctrl", {24'd0, ex_ctrl}, 32'd0);
    chk("reset_branch", {31'd0, branch_taken}, 32'd0);
    next_cycle();
    ctrl = 8'h00;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // EX/MEM beats MEM/WB on rs1
    rs1 = 5'd5; fwd_mem_we = 1'b1; fwd_mem_rd = 5'd5; fwd_mem_data = 32'd10;
    fwd_wb_we = 1'b1; fwd_wb_rd = 5'd5; fwd_wb_data = 32'd20;
    rs2 = 5'd6; rs2_data = 32'd1; rd = 5'd9; ctrl = 8'h01; alu_op = 4'd0;
    settle();
    chk("fwd_mem_priority", ex_result, 32'd11);
    chk("ex_ctrl_add", {24'd0, ex_ctrl}, 32'h01);
    chk("ex_rd_pass", {27'd0, ex_rd}, 32'd9);
    fwd_mem_rd = 5'd7;
    settle();
    chk("fwd_wb_only", ex_result, 32'd21);

    // x0 never forwards
    next_cycle();
    rs1 = 5'd0; fwd_mem_we = 1'b1; fwd_mem_rd = 5'd0; fwd_mem_data = 32'hDEAD;
    fwd_wb_we = 1'b0; rs1_data = 32'h11; rs2 = 5'd2; rs2_data = 32'd1;
    settle();
    chk("x0_no_fwd", ex_result, 32'h12);
    rs2 = 5'd7; fwd_mem_rd = 5'd7; fwd_mem_we = 1'b1;
    settle();
    chk("store_data_fwd", ex_store_data, 32'hDEAD);

    next_cycle();
    idle_inputs();
    rs1_data = 32'd10; imm = 32'd3; ctrl = 8'h03; alu_op = 4'd1;
    settle();
    chk("sub_imm", ex_result, 32'd7);
    rs1_data = 32'h8000_0000; imm = 32'd4; alu_op = 4'd7;
    settle();
    chk("sra", ex_result, 32'hF800_0000);
    alu_op = 4'd6;
    settle();
    chk("srl", ex_result, 32'h0800_0000);
    ctrl = 8'h01; rs1_data = 32'hFFFF_FFFF; rs2_data = 32'd1; alu_op = 4'd3;
    settle();
    chk("slt", ex_result, 32'd1);
    alu_op = 4'd4;
    settle();
    chk("sltu", ex_result, 32'd0);
    alu_op = 4'd12;
    settle();
    chk("op12_zero", ex_result, 32'd0);
    ctrl = 8'h41; pc = 32'h100; imm = 32'h20; alu_op = 4'd0;
    settle();
    chk("auipc", ex_result, 32'h120);

    // Branches
    next_cycle();
    idle_inputs();
    ctrl = 8'h10; pc = 32'h100; imm = 32'h20; rs1_data = 32'd5; rs2_data = 32'd5;
    alu_op = 4'd0;
    settle();
    chk("beq_taken", {31'd0, branch_taken}, 32'd1);
    chk("beq_target", branch_target, 32'h120);
    alu_op = 4'd1;
    settle();
    chk("bne_not_taken", {31'd0, branch_taken}, 32'd0);
    rs1_data = 32'hFFFF_FFFF; rs2_data = 32'd1; alu_op = 4'd4;
    settle();
    chk("blt_taken", {31'd0, branch_taken}, 32'd1);
    alu_op = 4'd6;
    settle();
    chk("bltu_not_taken", {31'd0, branch_taken}, 32'd0);

    // JALR / JAL
    ctrl = 8'h21; pc = 32'h200; imm = 32'h0; rs1_data = 32'h1003;
    settle();
    chk("jalr_taken", {31'd0, branch_taken}, 32'd1);
    chk("jalr_target", branch_target, 32'h1002);
    chk("jalr_link", ex_result, 32'h204);
    ctrl = 8'h61; imm = 32'h40;
    settle();
    chk("jal_target", branch_target, 32'h240);
    flush = 1'b1;
    settle();
    chk("flush_branch", {31'd0, branch_taken}, 32'd0);
    chk("flush_ex_ctrl", {24'd0, ex_ctrl}, 32'd0);

    // MUL 7*6: stall N..N+32, product at N+33
    next_cycle();
    idle_inputs();
    ctrl = 8'h81; alu_op = 4'd0; rs1_data = 32'd7; rs2_data = 32'd6;
    stall_cnt = 0;
    settle();
    chk("mul_start_ex_ctrl", {24'd0, ex_ctrl}, 32'd0);
    if (stall) stall_cnt++;
    for (int i = 0; i < 32; i++) begin
      next_cycle();
      if (stall) stall_cnt++;
    end
    chk("mul_stall_count", stall_cnt, 32'd33);
    next_cycle();
    chk("mul_done_stall", {31'd0, stall}, 32'd0);
    chk("mul_result", ex_result, 32'd42);
    chk("mul_done_ex_ctrl", {24'd0, ex_ctrl}, 32'h81);

    // MULHU with forwarding perturbed mid-BUSY
    next_cycle();
    ctrl = 8'h81; alu_op = 4'd3; rs1 = 5'd1; rs2 = 5'd2;
    rs1_data = 32'hFFFF_FFFF; rs2_data = 32'hFFFF_FFFF;
    for (int i = 0; i < 10; i++) next_cycle();
    rs1_data = 32'h0; fwd_mem_we = 1'b1; fwd_mem_rd = 5'd2; fwd_mem_data = 32'h3;
    stall_cnt = 0;
    for (int i = 0; i < 23; i++) begin
      if (!stall) stall_cnt++;
      next_cycle();
    end
    chk("mulhu_no_early_done", stall_cnt, 32'd0);
    chk("mulhu_stall_low", {31'd0, stall}, 32'd0);
    chk("mulhu_result", ex_result, 32'hFFFF_FFFE);

    // Flush at BUSY count 10
    next_cycle();
    idle_inputs();
    ctrl = 8'h81; rs1_data = 32'd3; rs2_data = 32'd4;
    for (int i = 0; i < 11; i++) next_cycle();
    settle();
    chk("pre_flush_stall", {31'd0, stall}, 32'd1);
    flush = 1'b1;
    settle();
    chk("flush_stall", {31'd0, stall}, 32'd0);
    chk("flush_mul_ex_ctrl", {24'd0, ex_ctrl}, 32'd0);
    next_cycle();
    flush = 1'b0; ctrl = 8'h00;
    settle();
    chk("post_flush_idle", {31'd0, stall}, 32'd0);

    // Async reset mid-BUSY, then a normal ADD
    next_cycle();
    ctrl = 8'h81;
    for (int i = 0; i < 6; i++) next_cycle();
    rst_n = 1'b0;
    settle();
    chk("rst_mid_busy_stall", {31'd0, stall}, 32'd0);
    chk("rst_mid_busy_ex_ctrl", {24'd0, ex_ctrl}, 32'd0);
    next_cycle();
    rst_n = 1'b1; ctrl = 8'h01; alu_op = 4'd0; rs1_data = 32'd3; rs2_data = 32'd4;
    settle();
    chk("post_rst_stall", {31'd0, stall}, 32'd0);
    chk("post_rst_add", ex_result, 32'd7);
    chk("post_rst_ex_ctrl", {24'd0, ex_ctrl}, 32'h01);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
